// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the dot-product path: field layout, exponent limits,
// canonical constants, unpacked-field record and the accumulator state encoding.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int WORK_W = 27;  // hidden + mantissa + guard + round + sticky

  typedef logic signed [9:0] exp_t;

  localparam exp_t EXP_BIAS = 10'sd127;
  localparam exp_t EMIN     = -10'sd126;
  localparam exp_t EMAX     = 10'sd127;

  localparam logic [31:0] FP32_QNAN = 32'hFFC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              denorm;   // exponent field is zero (includes +/-0)
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp32_fields_t;

  // Operand classification kept after unpack for the special-case decision.
  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp32_class_t;

  typedef enum logic [3:0] {
    ST_GET_TERM      = 4'd0,
    ST_UNPACK        = 4'd1,
    ST_SPECIAL_CASES = 4'd2,
    ST_ALIGN         = 4'd3,
    ST_ADD_0         = 4'd4,
    ST_ADD_1         = 4'd5,
    ST_NORMALISE_1   = 4'd6,
    ST_NORMALISE_2   = 4'd7,
    ST_ROUND         = 4'd8,
    ST_PACK          = 4'd9,
    ST_NEXT          = 4'd10,
    ST_PUT_Z         = 4'd11
  } state_t;

  // Denormals sit at EMIN without a hidden bit; everything else is simply unbiased.
  function automatic exp_t unbias(input logic [EXP_W-1:0] exp_field, input logic denorm);
    if (denorm) return EMIN;
    return exp_t'({2'b00, exp_field}) - EXP_BIAS;
  endfunction

endpackage

// File: rtl/fp_dot_accumulator_if.sv
// Term-in / sum-out stb/ack bundle between the FP32 multiplier, the accumulator
// and the downstream consumer.
interface fp_dot_accumulator_if;

  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  // Environment side: supplies product terms and consumes sums.
  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_stb
  );

  // Accumulator side.
  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_stb
  );

endinterface

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split with denormal/zero/inf/NaN classification.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]  word,
  output fp32_fields_t fields
);

  // NOTE: every field is assigned on every path, so no latch can be inferred.
  always_comb begin
    fields.sign    = word[31];
    fields.exp     = word[30:23];
    fields.mant    = word[22:0];
    fields.denorm  = (word[30:23] == 8'h00);
    fields.is_zero = (word[30:23] == 8'h00) && (word[22:0] == 23'd0);
    fields.is_inf  = (word[30:23] == 8'hFF) && (word[22:0] == 23'd0);
    fields.is_nan  = (word[30:23] == 8'hFF) && (word[22:0] != 23'd0);
  end

endmodule

// File: rtl/fp_dot_accumulator.sv
// FP32 running-sum stage: accumulates VEC_LEN product terms with a multi-cycle
// IEEE-754 adder (round-to-nearest-even) and hands the sum out on a stb/ack port.
module fp_dot_accumulator
  import fp32_pkg::*;
#(
  parameter int unsigned VEC_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_dot_accumulator_if.slave  bus
);

  localparam int               CNT_W    = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  state_t state, state_next;

  logic              input_a_ack_q, input_a_ack_d;
  logic              output_z_stb_q, output_z_stb_d;
  logic              in_xfer, out_xfer;

  logic [31:0]       acc, term, output_z_q;
  logic [CNT_W-1:0]  count;

  fp32_fields_t      acc_f, term_f;
  fp32_class_t       a_c, b_c;
  logic [WORK_W-1:0] a_m, b_m;
  exp_t              a_e, b_e;

  logic [WORK_W:0]   sum;
  logic [23:0]       z_m;
  exp_t              z_e;
  logic              z_s, guard_bit, round_bit, sticky;

  logic              bypass;
  logic [31:0]       bypass_word;
  logic              spec_hit;
  logic [31:0]       spec_word;
  logic [31:0]       packed_word;
  logic [7:0]        z_exp_field;
  logic              norm1_shift, norm2_shift;

  assign bus.input_a_ack  = input_a_ack_q;
  assign bus.output_z_stb = output_z_stb_q;
  assign bus.output_z     = output_z_q;

  assign in_xfer  = input_a_ack_q && bus.input_a_stb;
  assign out_xfer = output_z_stb_q && bus.output_z_ack;

  fp32_unpack u_unpack_acc  (.word(acc),  .fields(acc_f));
  fp32_unpack u_unpack_term (.word(term), .fields(term_f));

  assign norm1_shift = !z_m[23] && (z_e > EMIN);
  assign norm2_shift = (z_e < EMIN);

  // Specials resolve to a whole result word that bypasses the arithmetic path.
  always_comb begin
    spec_hit  = 1'b1;
    spec_word = FP32_QNAN;
    if (a_c.is_nan || b_c.is_nan)                         spec_word = FP32_QNAN;
    else if (a_c.is_inf && b_c.is_inf && (a_c.sign != b_c.sign)) spec_word = FP32_QNAN;
    else if (a_c.is_inf)                                  spec_word = acc;
    else if (b_c.is_inf)                                  spec_word = term;
    else if (a_c.is_zero && b_c.is_zero)                  spec_word = {a_c.sign & b_c.sign, 31'd0};
    else if (a_c.is_zero)                                 spec_word = term;
    else if (b_c.is_zero)                                 spec_word = acc;
    else                                                  spec_hit  = 1'b0;
  end

  always_comb begin
    z_exp_field = 8'(z_e + EXP_BIAS);
    if (z_e > EMAX)
      packed_word = {z_s, FP32_PINF[30:0]};
    else if ((z_e == EMIN) && !z_m[23])
      packed_word = {z_s, 8'd0, z_m[22:0]};
    else
      packed_word = {z_s, z_exp_field, z_m[22:0]};
  end

  // ---------------------------------------------------------------- FSM: state register
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_GET_TERM;
      input_a_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
    end else begin
      state          <= state_next;
      input_a_ack_q  <= input_a_ack_d;
      output_z_stb_q <= output_z_stb_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_GET_TERM:      if (in_xfer) state_next = ST_UNPACK;
      ST_UNPACK:        state_next = ST_SPECIAL_CASES;
      ST_SPECIAL_CASES: state_next = spec_hit ? ST_PACK : ST_ALIGN;
      ST_ALIGN:         if (a_e == b_e) state_next = ST_ADD_0;
      ST_ADD_0:         state_next = ST_ADD_1;
      ST_ADD_1:         state_next = (sum == '0) ? ST_PACK : ST_NORMALISE_1;
      ST_NORMALISE_1:   if (!norm1_shift) state_next = ST_NORMALISE_2;
      ST_NORMALISE_2:   if (!norm2_shift) state_next = ST_ROUND;
      ST_ROUND:         state_next = ST_PACK;
      ST_PACK:          state_next = ST_NEXT;
      ST_NEXT:          state_next = (count == LAST_IDX) ? ST_PUT_Z : ST_GET_TERM;
      ST_PUT_Z:         if (out_xfer) state_next = ST_GET_TERM;
      default:          state_next = ST_GET_TERM;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // Handshake outputs are registered: ack/stb rise one cycle after entering the
  // state and drop one cycle after the transfer.
  always_comb begin
    input_a_ack_d  = (state == ST_GET_TERM) && !in_xfer;
    output_z_stb_d = (state == ST_PUT_Z)    && !out_xfer;
  end

  // ---------------------------------------------------------------- architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= 32'd0;
      count      <= '0;
      output_z_q <= 32'd0;
    end else begin
      case (state)
        ST_PACK: acc <= bypass ? bypass_word : packed_word;
        ST_NEXT: begin
          count <= count + CNT_W'(1);
          if (count == LAST_IDX) output_z_q <= acc;
        end
        ST_PUT_Z: if (out_xfer) begin
          acc   <= 32'd0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- adder datapath
  // NOTE: working registers are always loaded before they are read, so they carry
  // no reset; a reset only has to clear the architectural state above.
  always_ff @(posedge clk) begin
    case (state)
      ST_GET_TERM: if (in_xfer) term <= bus.input_a;

      ST_UNPACK: begin
        a_c <= '{sign: acc_f.sign,  is_zero: acc_f.is_zero,  is_inf: acc_f.is_inf,  is_nan: acc_f.is_nan};
        b_c <= '{sign: term_f.sign, is_zero: term_f.is_zero, is_inf: term_f.is_inf, is_nan: term_f.is_nan};
        a_m <= {~acc_f.denorm,  acc_f.mant,  3'b000};
        b_m <= {~term_f.denorm, term_f.mant, 3'b000};
        a_e <= unbias(acc_f.exp,  acc_f.denorm);
        b_e <= unbias(term_f.exp, term_f.denorm);
      end

      ST_SPECIAL_CASES: begin
        bypass      <= spec_hit;
        bypass_word <= spec_word;
      end

      // One bit per cycle; bits leaving the bottom collapse into the sticky position.
      ST_ALIGN: begin
        if (a_e > b_e) begin
          b_e <= b_e + 10'sd1;
          b_m <= {1'b0, b_m[WORK_W-1:2], b_m[1] | b_m[0]};
        end else if (a_e < b_e) begin
          a_e <= a_e + 10'sd1;
          a_m <= {1'b0, a_m[WORK_W-1:2], a_m[1] | a_m[0]};
        end
      end

      ST_ADD_0: begin
        z_e <= a_e;
        if (a_c.sign == b_c.sign) begin
          sum <= {1'b0, a_m} + {1'b0, b_m};
          z_s <= a_c.sign;
        end else if (a_m >= b_m) begin
          sum <= {1'b0, a_m - b_m};
          z_s <= a_c.sign;
        end else begin
          sum <= {1'b0, b_m - a_m};
          z_s <= b_c.sign;
        end
      end

      ST_ADD_1: begin
        if (sum == '0) begin
          bypass      <= 1'b1;
          bypass_word <= 32'd0;  // exact cancellation is always +0
        end else if (sum[WORK_W]) begin
          z_m       <= sum[27:4];
          guard_bit <= sum[3];
          round_bit <= sum[2];
          sticky    <= sum[1] | sum[0];
          z_e       <= z_e + 10'sd1;
        end else begin
          z_m       <= sum[26:3];
          guard_bit <= sum[2];
          round_bit <= sum[1];
          sticky    <= sum[0];
        end
      end

      ST_NORMALISE_1: if (norm1_shift) begin
        z_e       <= z_e - 10'sd1;
        z_m       <= {z_m[22:0], guard_bit};
        guard_bit <= round_bit;
        round_bit <= 1'b0;
      end

      ST_NORMALISE_2: if (norm2_shift) begin
        z_e       <= z_e + 10'sd1;
        z_m       <= {1'b0, z_m[23:1]};
        guard_bit <= z_m[0];
        round_bit <= guard_bit;
        sticky    <= sticky | round_bit;
      end

      ST_ROUND: if (guard_bit && (round_bit || sticky || z_m[0])) begin
        z_m <= z_m + 24'd1;
        if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_dot_accumulator.sv
// Self-checking bench for fp_dot_accumulator (VEC_LEN=4): directed corner vectors,
// handshake/reset behaviour and random vectors against a real-arithmetic model.
module tb_fp_dot_accumulator;

  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_dot_accumulator_if bus ();

  fp_dot_accumulator #(.VEC_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // FP32 value as a double (exact for every finite FP32 normal/zero).
  function automatic real to_real(input logic [31:0] w);
    logic [63:0] b;
    if (w[30:0] == 31'd0) return 0.0;
    b = {w[31], 11'(int'(w[30:23]) + 896), w[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Round a double in the FP32 normal range to FP32, ties to even; zero gives +0.
  function automatic logic [31:0] round32(input real r);
    logic [63:0] b;
    logic [24:0] m;
    logic [28:0] rem;
    int          e;
    if (r == 0.0) return 32'd0;
    b   = $realtobits(r);
    e   = int'(b[62:52]) - 1023;
    m   = {2'b01, b[51:29]};
    rem = b[28:0];
    if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    return {b[63], 8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] t0, t1, t2, t3);
    logic [31:0] acc;
    acc = 32'd0;
    acc = round32(to_real(acc) + to_real(t0));
    acc = round32(to_real(acc) + to_real(t1));
    acc = round32(to_real(acc) + to_real(t2));
    acc = round32(to_real(acc) + to_real(t3));
    return acc;
  endfunction

  task automatic send_term(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    bus.input_a     = w;
    bus.input_a_stb = 1'b1;
    while (!bus.input_a_ack && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("term_ack_timeout", 32'(bus.input_a_ack), 32'd1);
    else @(negedge clk);
    bus.input_a_stb = 1'b0;
  endtask

  // Waits for the sum, holds ack low for 'hold' cycles checking stability and
  // input backpressure, then accepts it.
  task automatic recv_sum(input int hold, output logic [31:0] got);
    int n = 0;
    bus.output_z_ack = 1'b0;
    while (!bus.output_z_stb && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("sum_stb_timeout", 32'(bus.output_z_stb), 32'd1);
    got = bus.output_z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stb",    32'(bus.output_z_stb), 32'd1);
      check("hold_data",   bus.output_z,          got);
      check("hold_in_ack", 32'(bus.input_a_ack),  32'd0);
    end
    bus.output_z_ack = 1'b1;
    @(negedge clk);
    bus.output_z_ack = 1'b0;
    check("stb_drop", 32'(bus.output_z_stb), 32'd0);
  endtask

  task automatic run_vector(input string tag, input logic [31:0] t0, t1, t2, t3,
                            input logic [31:0] exp, input int hold);
    logic [31:0] got;
    send_term(t0);
    send_term(t1);
    send_term(t2);
    send_term(t3);
    recv_sum(hold, got);
    check(tag, got, exp);
  endtask

  function automatic logic [31:0] rand_term();
    return {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] r0, r1, r2, r3;

    rst              = 1'b1;
    bus.input_a      = 32'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ack",   32'(bus.input_a_ack),  32'd0);
    check("rst_out_stb",  32'(bus.output_z_stb), 32'd0);
    check("rst_output_z", bus.output_z,          32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ack_rise", 32'(bus.input_a_ack), 32'd1);

    run_vector("four_ones",   32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 5);
    run_vector("cancel_then", 32'h3FC00000, 32'hBFC00000, 32'h40000000, 32'h00000000, 32'h40000000, 2);
    run_vector("cancel_pos0", 32'hBFC00000, 32'h3FC00000, 32'h00000000, 32'h00000000, 32'h00000000, 2);
    run_vector("nan_sticky",  32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'hFFC00000, 2);
    run_vector("inf_minus",   32'h7F800000, 32'hFF800000, 32'h00000000, 32'h00000000, 32'hFFC00000, 2);
    run_vector("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 32'h7F800000, 2);
    run_vector("tie_even",    32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800000, 2);
    run_vector("tie_odd_up",  32'h3F800001, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800002, 2);
    run_vector("denormal",    32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000004, 2);

    for (int v = 0; v < 16; v++) begin
      r0 = rand_term();
      r1 = rand_term();
      r2 = rand_term();
      r3 = rand_term();
      run_vector("random", r0, r1, r2, r3, model_sum(r0, r1, r2, r3), 1);
    end

    run_vector("long_hold", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 20);

    // Reset partway through a vector discards the partial sum.
    send_term(32'h40400000);
    send_term(32'h40400000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ack",   32'(bus.input_a_ack),  32'd0);
    check("midrst_out_stb",  32'(bus.output_z_stb), 32'd0);
    check("midrst_output_z", bus.output_z,          32'd0);
    run_vector("after_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
